// File: rtl/mem_stack_sequencer_pkg.sv
// Shared types for the memory-stage stack sequencer: FSM states, sp operations,
// request priority and the write-back payload.
package mem_stack_sequencer_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned RD_W   = 3;
  localparam logic [1:0]  EN_STACK = 2'b01;

  // PUSH_HI and POP_LO have no state of their own: they are the IDLE accept cycle.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PUSH_LO  = 2'd1,
    ST_POP_HI   = 2'd2,
    ST_POP_DONE = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    SP_NONE = 3'd0,
    SP_INC1 = 3'd1,
    SP_DEC1 = 3'd2,
    SP_INC2 = 3'd3,
    SP_DEC2 = 3'd4
  } sp_op_e;

  // Enumeration order is the acceptance priority, highest first.
  typedef enum logic [2:0] {
    REQ_NONE  = 3'd0,
    REQ_INT   = 3'd1,
    REQ_CALL  = 3'd2,
    REQ_RTI   = 3'd3,
    REQ_RET   = 3'd4,
    REQ_STACK = 3'd5,
    REQ_MEM   = 3'd6
  } req_e;

  typedef struct packed {
    logic              rw;
    logic [RD_W-1:0]   rd;
    logic              mtr;
    logic [DATA_W-1:0] alu;
  } wb_t;

  function automatic req_e pick_req(input logic int_r, input logic call_r,
                                    input logic rti_r, input logic ret_r,
                                    input logic stack_r, input logic mem_r);
    req_e req;
    req = REQ_NONE;
    if (int_r)        req = REQ_INT;
    else if (call_r)  req = REQ_CALL;
    else if (rti_r)   req = REQ_RTI;
    else if (ret_r)   req = REQ_RET;
    else if (stack_r) req = REQ_STACK;
    else if (mem_r)   req = REQ_MEM;
    return req;
  endfunction

endpackage

// File: rtl/mem_stack_sequencer_sp_unit.sv
// Stack pointer register with +/-1 and +/-2 steps; flags any step that wraps
// past either end of the stack into a sticky error.
module mem_stack_sequencer_sp_unit
  import mem_stack_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned SP_INIT = (2**ADDR_W) - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  sp_op_e            i_op,
  output logic [ADDR_W-1:0] o_sp,
  output logic              o_err
);

  localparam logic [ADDR_W-1:0] SP_RST = ADDR_W'(SP_INIT);

  logic [ADDR_W-1:0] r_sp;
  logic              r_err;
  logic [ADDR_W-1:0] w_sp_nxt;
  logic              w_bound;

  // Next pointer and wrap detection for the requested step.
  always_comb begin
    w_sp_nxt = r_sp;
    w_bound  = 1'b0;
    case (i_op)
      SP_INC1: begin
        w_sp_nxt = r_sp + ADDR_W'(1);
        w_bound  = (r_sp == SP_RST);
      end
      SP_DEC1: begin
        w_sp_nxt = r_sp - ADDR_W'(1);
        w_bound  = (r_sp == '0);
      end
      SP_INC2: begin
        w_sp_nxt = r_sp + ADDR_W'(2);
        w_bound  = (r_sp == SP_RST) || (r_sp == SP_RST - ADDR_W'(1));
      end
      SP_DEC2: begin
        w_sp_nxt = r_sp - ADDR_W'(2);
        w_bound  = (r_sp < ADDR_W'(2));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp  <= SP_RST;
      r_err <= 1'b0;
    end else begin
      r_sp  <= w_sp_nxt;
      r_err <= r_err | w_bound;
    end
  end

  assign o_sp  = r_sp;
  assign o_err = r_err;

endmodule

// File: rtl/mem_stack_sequencer.sv
// Memory-stage sequencer: issues loads/stores/stack ops, runs the two-word PC
// push (CALL/INT) and pop (RET/RTI), and registers the write-back fields.
module mem_stack_sequencer
  import mem_stack_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned SP_INIT = (2**ADDR_W) - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mr,
  input  logic              mw,
  input  logic              mtr,
  input  logic              rw,
  input  logic              is_push,
  input  logic [1:0]        en_push_pop,
  input  logic              call_req,
  input  logic              int_req,
  input  logic              ret_req,
  input  logic              rti_req,
  input  logic [31:0]       pc_in,
  input  logic [15:0]       alu_out,
  input  logic [15:0]       read_data2,
  input  logic [2:0]        rd,
  input  logic [3:0]        freezed_ccr,
  input  logic [15:0]       mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic              stall,
  output logic              pc_load,
  output logic [31:0]       pc_target,
  output logic              ccr_load,
  output logic [3:0]        ccr_out,
  output logic              wb_rw,
  output logic [2:0]        wb_rd,
  output logic [15:0]       wb_data,
  output logic              stack_err
);

  state_e            r_state;
  state_e            w_state_nxt;
  req_e              w_req;
  sp_op_e            w_sp_op;
  logic [ADDR_W-1:0] w_sp;
  logic              r_is_rti;
  logic [15:0]       r_lo;
  wb_t               r_wb;

  assign w_req = pick_req(int_req, call_req, rti_req, ret_req,
                          en_push_pop == EN_STACK, mr | mw);

  mem_stack_sequencer_sp_unit #(
    .ADDR_W  (ADDR_W),
    .SP_INIT (SP_INIT)
  ) u_sp (
    .clk   (clk),
    .rst_n (rst_n),
    .i_op  (w_sp_op),
    .o_sp  (w_sp),
    .o_err (stack_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        case (w_req)
          REQ_INT, REQ_CALL: w_state_nxt = ST_PUSH_LO;
          REQ_RTI, REQ_RET:  w_state_nxt = ST_POP_HI;
          default:           w_state_nxt = ST_IDLE;
        endcase
      end
      ST_PUSH_LO:  w_state_nxt = ST_IDLE;
      ST_POP_HI:   w_state_nxt = ST_POP_DONE;
      ST_POP_DONE: w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Memory strobes, stall, PC/flag restore and sp step for the current cycle.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    stall     = 1'b0;
    pc_load   = 1'b0;
    pc_target = '0;
    ccr_load  = 1'b0;
    ccr_out   = '0;
    w_sp_op   = SP_NONE;
    case (r_state)
      ST_IDLE: begin
        case (w_req)
          REQ_INT, REQ_CALL: begin
            mem_we    = 1'b1;
            mem_addr  = w_sp;
            mem_wdata = pc_in[31:16];
            stall     = 1'b1;
          end
          REQ_RTI, REQ_RET: begin
            mem_re   = 1'b1;
            mem_addr = w_sp + ADDR_W'(1);
            stall    = 1'b1;
          end
          REQ_STACK: begin
            if (is_push) begin
              mem_we    = 1'b1;
              mem_addr  = w_sp;
              mem_wdata = read_data2;
              w_sp_op   = SP_DEC1;
            end else begin
              mem_re   = 1'b1;
              mem_addr = w_sp + ADDR_W'(1);
              w_sp_op  = SP_INC1;
            end
          end
          REQ_MEM: begin
            mem_addr = alu_out[ADDR_W-1:0];
            if (mr) begin
              mem_re = 1'b1;
            end else begin
              mem_we    = 1'b1;
              mem_wdata = read_data2;
            end
          end
          default: ;
        endcase
      end
      ST_PUSH_LO: begin
        mem_we    = 1'b1;
        mem_addr  = w_sp - ADDR_W'(1);
        mem_wdata = pc_in[15:0];
        w_sp_op   = SP_DEC2;
      end
      ST_POP_HI: begin
        mem_re   = 1'b1;
        mem_addr = w_sp + ADDR_W'(2);
        stall    = 1'b1;
      end
      ST_POP_DONE: begin
        pc_load   = 1'b1;
        pc_target = {mem_rdata, r_lo};
        w_sp_op   = SP_INC2;
        if (r_is_rti) begin
          ccr_load = 1'b1;
          ccr_out  = freezed_ccr;
        end
      end
      default: ;
    endcase
  end

  // Write-back capture on every IDLE accept; enable drops in sequence cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb     <= '0;
      r_is_rti <= 1'b0;
      r_lo     <= '0;
    end else begin
      if (r_state == ST_IDLE) begin
        r_wb     <= '{rw: rw, rd: rd, mtr: mtr, alu: alu_out};
        r_is_rti <= (w_req == REQ_RTI);
      end else begin
        r_wb.rw <= 1'b0;
      end
      if (r_state == ST_POP_HI) r_lo <= mem_rdata;
    end
  end

  assign wb_rw   = r_wb.rw;
  assign wb_rd   = r_wb.rd;
  assign wb_data = r_wb.mtr ? mem_rdata : r_wb.alu;

endmodule

// File: tb/tb_mem_stack_sequencer.sv
// Randomized bench for mem_stack_sequencer against an instruction-level model
// of the stack, data memory and write-back.
module tb_mem_stack_sequencer;

  localparam int unsigned AW = 11;
  localparam int SPI  = 2047;
  localparam int MASK = 2047;
  localparam int K_NOP = 0, K_LD = 1, K_ST = 2, K_PUSH = 3, K_POP = 4,
                 K_CALL = 5, K_INT = 6, K_RET = 7, K_RTI = 8;

  logic          clk, rst_n;
  logic          mr, mw, mtr, rw, is_push;
  logic [1:0]    en_push_pop;
  logic          call_req, int_req, ret_req, rti_req;
  logic [31:0]   pc_in;
  logic [15:0]   alu_out, read_data2;
  logic [2:0]    rd;
  logic [3:0]    freezed_ccr;
  logic [15:0]   mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          mem_we, mem_re, stall, pc_load, ccr_load, wb_rw, stack_err;
  logic [31:0]   pc_target;
  logic [3:0]    ccr_out;
  logic [2:0]    wb_rd;
  logic [15:0]   wb_data;

  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [15:0]   pl_data;
  logic [15:0]   mem   [0:2047];
  logic [15:0]   mem_m [0:2047];

  int          sp_m;
  bit          err_m;
  bit          pend;
  logic        pend_rw;
  logic [2:0]  pend_rd;
  logic [15:0] pend_data;
  int          n_vec, n_err;

  mem_stack_sequencer dut (
    .clk(clk), .rst_n(rst_n), .mr(mr), .mw(mw), .mtr(mtr), .rw(rw),
    .is_push(is_push), .en_push_pop(en_push_pop), .call_req(call_req),
    .int_req(int_req), .ret_req(ret_req), .rti_req(rti_req), .pc_in(pc_in),
    .alu_out(alu_out), .read_data2(read_data2), .rd(rd),
    .freezed_ccr(freezed_ccr), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .stall(stall),
    .pc_load(pc_load), .pc_target(pc_target), .ccr_load(ccr_load),
    .ccr_out(ccr_out), .wb_rw(wb_rw), .wb_rd(wb_rd), .wb_data(wb_data),
    .stack_err(stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous data memory; the preload port is only used while idle in reset.
  always @(posedge clk) begin
    if (mem_we)     mem[mem_addr] <= mem_wdata;
    else if (pl_en) mem[pl_addr]  <= pl_data;
    if (mem_re)     mem_rdata     <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic set_nop();
    mr = 0; mw = 0; mtr = 0; rw = 0; is_push = 0; en_push_pop = 2'b00;
    call_req = 0; int_req = 0; ret_req = 0; rti_req = 0;
    pc_in = '0; alu_out = '0; read_data2 = '0; rd = '0; freezed_ccr = '0;
  endtask

  task automatic preload(input int a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = AW'(a); pl_data = d; mem_m[a] = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic model_reset();
    sp_m = SPI; err_m = 1'b0; pend = 1'b0;
  endtask

  // Apply one instruction, check every cycle it occupies, then advance the model.
  task automatic exec(input int kind, input logic [15:0] d, input logic [15:0] a,
                      input logic [31:0] pc, input logic [3:0] ccr,
                      input logic rw_i, input logic [2:0] rd_i, input logic mtr_i);
    int n, s1, s2, m1;
    logic e_we, e_re, e_st, e_pl, e_cl;
    logic [AW-1:0] e_addr;
    logic [15:0] e_wd, rdv;
    logic [31:0] e_pt;
    logic [3:0]  e_co;
    bit seq;
    s1 = (sp_m + 1) & MASK; s2 = (sp_m + 2) & MASK; m1 = (sp_m - 1) & MASK;
    seq = (kind >= K_CALL);
    set_nop();
    is_push = 1'($urandom_range(0, 1));
    if (seq) begin
      en_push_pop = 2'($urandom_range(0, 3));
      mr = 1'($urandom_range(0, 1));
    end
    case (kind)
      K_LD:   mr = 1'b1;
      K_ST:   mw = 1'b1;
      K_PUSH: begin en_push_pop = 2'b01; is_push = 1'b1; mr = 1'($urandom_range(0, 1)); end
      K_POP:  begin en_push_pop = 2'b01; is_push = 1'b0; mr = 1'($urandom_range(0, 1)); end
      K_INT:  begin
        int_req = 1'b1; call_req = 1'($urandom_range(0, 1));
        rti_req = 1'($urandom_range(0, 1)); ret_req = 1'($urandom_range(0, 1));
      end
      K_CALL: begin
        call_req = 1'b1; rti_req = 1'($urandom_range(0, 1)); ret_req = 1'($urandom_range(0, 1));
      end
      K_RTI:  begin rti_req = 1'b1; ret_req = 1'($urandom_range(0, 1)); end
      K_RET:  ret_req = 1'b1;
      default: ;
    endcase
    alu_out = a; read_data2 = d; pc_in = pc; freezed_ccr = ccr;
    rw = rw_i; rd = rd_i; mtr = mtr_i;
    n = (kind == K_CALL || kind == K_INT) ? 2 : (kind == K_RET || kind == K_RTI) ? 3 : 1;
    rdv = (kind == K_LD) ? mem_m[a[10:0]] : (kind == K_POP) ? mem_m[s1] : 16'h0;
    for (int c = 0; c < n; c++) begin
      e_we = 0; e_re = 0; e_st = 0; e_pl = 0; e_cl = 0;
      e_addr = '0; e_wd = '0; e_pt = '0; e_co = '0;
      case (kind)
        K_LD:   begin e_re = 1; e_addr = a[10:0]; end
        K_ST:   begin e_we = 1; e_addr = a[10:0]; e_wd = d; end
        K_PUSH: begin e_we = 1; e_addr = AW'(sp_m); e_wd = d; end
        K_POP:  begin e_re = 1; e_addr = AW'(s1); end
        K_CALL, K_INT: begin
          e_we = 1; e_st = (c == 0);
          e_addr = (c == 0) ? AW'(sp_m) : AW'(m1);
          e_wd   = (c == 0) ? pc[31:16] : pc[15:0];
        end
        K_RET, K_RTI: begin
          if (c < 2) begin
            e_re = 1; e_st = 1; e_addr = (c == 0) ? AW'(s1) : AW'(s2);
          end else begin
            e_pl = 1; e_pt = {mem_m[s2], mem_m[s1]};
            e_cl = (kind == K_RTI); e_co = (kind == K_RTI) ? ccr : 4'h0;
          end
        end
        default: ;
      endcase
      @(negedge clk);
      if (c == 0) chk("stack_err", 32'(stack_err), 32'(err_m));
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("mem_re", 32'(mem_re), 32'(e_re));
      chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
      chk("stall", 32'(stall), 32'(e_st));
      chk("pc_load", 32'(pc_load), 32'(e_pl));
      chk("pc_target", pc_target, e_pt);
      chk("ccr_load", 32'(ccr_load), 32'(e_cl));
      chk("ccr_out", 32'(ccr_out), 32'(e_co));
      chk("wb_rw", 32'(wb_rw), pend ? 32'(pend_rw) : 32'h0);
      if (pend) begin
        chk("wb_rd", 32'(wb_rd), 32'(pend_rd));
        chk("wb_data", 32'(wb_data), 32'(pend_data));
      end
      pend = 1'b0;
      if (c == 0) begin
        pend = 1'b1; pend_rw = rw_i; pend_rd = rd_i;
        pend_data = mtr_i ? rdv : a;
      end
      @(posedge clk); #1;
    end
    case (kind)
      K_ST:   mem_m[a[10:0]] = d;
      K_PUSH: begin if (sp_m == 0) err_m = 1; mem_m[sp_m] = d; sp_m = m1; end
      K_POP:  begin if (sp_m == SPI) err_m = 1; sp_m = s1; end
      K_CALL, K_INT: begin
        if (sp_m < 2) err_m = 1;
        mem_m[sp_m] = pc[31:16]; mem_m[m1] = pc[15:0];
        sp_m = (sp_m - 2) & MASK;
      end
      K_RET, K_RTI: begin if (sp_m >= SPI - 1) err_m = 1; sp_m = s2; end
      default: ;
    endcase
    chk("sp", 32'(dut.w_sp), 32'(sp_m));
  endtask

  initial begin
    int kind, depth, ndiff;
    n_vec = 0; n_err = 0;
    set_nop();
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) preload(i, 16'($urandom));
    preload(16, 16'h1234);
    model_reset();
    @(negedge clk);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_re", 32'(mem_re), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_pc_load", 32'(pc_load), 32'h0);
    chk("rst_wb_rw", 32'(wb_rw), 32'h0);
    chk("rst_stack_err", 32'(stack_err), 32'h0);
    chk("rst_sp", 32'(dut.w_sp), 32'h7FF);
    @(posedge clk); #1;
    rst_n = 1'b1;

    exec(K_CALL, 16'h0, 16'h0, 32'h0001_0ABC, 4'h0, 0, 3'd0, 0);
    chk("call_hi_word", 32'(mem[2047]), 32'h0001);
    chk("call_lo_word", 32'(mem[2046]), 32'h0ABC);
    chk("call_sp", 32'(dut.w_sp), 32'h7FD);
    exec(K_RET, 16'h0, 16'h0, 32'h0, 4'h0, 0, 3'd0, 0);
    exec(K_INT, 16'h0, 16'h0, 32'h0000_0042, 4'h0, 0, 3'd0, 0);
    exec(K_RTI, 16'h0, 16'h0, 32'h0, 4'b1010, 0, 3'd0, 0);
    exec(K_PUSH, 16'hBEEF, 16'h0, 32'h0, 4'h0, 0, 3'd0, 0);
    exec(K_POP, 16'h0, 16'h0, 32'h0, 4'h0, 1, 3'd3, 1);
    exec(K_LD, 16'h0, 16'h0010, 32'h0, 4'h0, 1, 3'd5, 1);
    exec(K_LD, 16'h0, 16'h0010, 32'h0, 4'h0, 1, 3'd6, 0);
    exec(K_NOP, 16'h0, 16'h0, 32'h0, 4'h0, 0, 3'd0, 0);

    // Reset while the pop sequence sits in its second read.
    exec(K_CALL, 16'h0, 16'h0, 32'h1234_5678, 4'h0, 0, 3'd0, 0);
    set_nop(); ret_req = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pophi_stall", 32'(stall), 32'h1);
    rst_n = 1'b0; set_nop(); #1;
    chk("abort_pc_load", 32'(pc_load), 32'h0);
    chk("abort_stall", 32'(stall), 32'h0);
    chk("abort_sp", 32'(dut.w_sp), 32'h7FF);
    @(posedge clk);
    @(negedge clk);
    chk("abort_pc_load2", 32'(pc_load), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    exec(K_NOP, 16'h0, 16'h0, 32'h0, 4'h0, 0, 3'd0, 0);

    exec(K_POP, 16'h0, 16'h0, 32'h0, 4'h0, 1, 3'd1, 1);
    exec(K_NOP, 16'h0, 16'h0, 32'h0, 4'h0, 0, 3'd0, 0);
    exec(K_PUSH, 16'h5A5A, 16'h0, 32'h0, 4'h0, 0, 3'd0, 0);
    exec(K_NOP, 16'h0, 16'h0, 32'h0, 4'h0, 0, 3'd0, 0);
    chk("err_sticky", 32'(stack_err), 32'h1);

    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 400; i++) begin
      kind  = $urandom_range(0, 8);
      depth = SPI - sp_m;
      if (kind == K_POP && depth < 1) kind = K_PUSH;
      if ((kind == K_RET || kind == K_RTI) && depth < 2) kind = K_CALL;
      if (kind == K_PUSH && depth > 60) kind = K_POP;
      if ((kind == K_CALL || kind == K_INT) && depth > 60) kind = K_RET;
      exec(kind, 16'($urandom), 16'($urandom_range(0, 31)), $urandom,
           4'($urandom), 1'($urandom_range(0, 1)), 3'($urandom),
           (kind == K_LD || kind == K_POP) ? 1'($urandom_range(0, 1)) : 1'b0);
    end
    exec(K_NOP, 16'h0, 16'h0, 32'h0, 4'h0, 0, 3'd0, 0);

    ndiff = 0;
    for (int i = 0; i < 2048; i++) if (mem[i] !== mem_m[i]) ndiff++;
    chk("mem_image_diffs", 32'(ndiff), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
